// File: rtl/lsu_byte_sequencer.sv
// Word-to-byte load/store sequencer: turns one 32-bit lw/sw request into four
// little-endian byte transactions on a req/ack memory port and reports the result.
module lsu_byte_sequencer #(
  parameter int ADDR_W      = 20,
  parameter bit CHECK_ALIGN = 1'b1,
  parameter int TIMEOUT     = 15
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack
);

  typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

  // Last legal word address, widened so ADDR_W=32 still compares correctly.
  localparam logic [32:0] MAX_ADDR = (33'd1 << ADDR_W) - 33'd4;
  localparam logic [7:0]  TO_LAST  = 8'(TIMEOUT - 1);

  state_t              state;
  logic                wr_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic [31:0]         rdata_q;
  logic [1:0]          k;
  logic [7:0]          tcnt;

  function automatic logic addr_err(input logic [31:0] a);
    addr_err = (CHECK_ALIGN && (a[1:0] != 2'b00)) || ({1'b0, a} > MAX_ADDR);
  endfunction

  function automatic logic [7:0] lane(input logic [31:0] w, input logic [1:0] i);
    lane = w[{i, 3'b000} +: 8];
  endfunction

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state      <= IDLE;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      k          <= '0;
      tcnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_ready && req_valid) begin
            req_ready <= 1'b0;
            wr_q      <= req_write;
            addr_q    <= req_addr[ADDR_W-1:0];
            wdata_q   <= req_wdata;
            rdata_q   <= '0;
            k         <= '0;
            tcnt      <= '0;
            if (addr_err(req_addr)) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else begin
              state     <= XFER;
              mem_req   <= 1'b1;
              mem_we    <= req_write;
              mem_addr  <= req_addr[ADDR_W-1:0];
              mem_wdata <= req_write ? req_wdata[7:0] : 8'h00;
            end
          end
        end

        // One byte per ack; mem_req stays up so a zero-wait memory streams.
        XFER: begin
          if (mem_ack) begin
            tcnt <= '0;
            if (!wr_q) rdata_q[{k, 3'b000} +: 8] <= mem_rdata;
            if (k == 2'd3) begin
              state      <= RESP;
              mem_req    <= 1'b0;
              mem_we     <= 1'b0;
              mem_addr   <= '0;
              mem_wdata  <= '0;
              resp_valid <= 1'b1;
              resp_err   <= 1'b0;
              resp_rdata <= wr_q ? 32'h0 : {mem_rdata, rdata_q[23:0]};
            end else begin
              k         <= k + 2'd1;
              mem_addr  <= addr_q + {{(ADDR_W-2){1'b0}}, k + 2'd1};
              mem_wdata <= wr_q ? lane(wdata_q, k + 2'd1) : 8'h00;
            end
          end else if (tcnt == TO_LAST) begin
            // Abort without rollback: bytes already acked remain in memory.
            state      <= RESP;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= '0;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end

        RESP: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
          req_ready  <= 1'b1;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_byte_sequencer.sv
// Bench for lsu_byte_sequencer: behavioural byte memory with wait states and an
// ack budget, plus a word-level reference model of expected responses.
module tb_lsu_byte_sequencer;
  localparam int ADDR_W = 20;
  localparam int TIMEOUT = 15;

  logic              CLK = 1'b0;
  logic              RESET = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_write = 1'b0;
  logic [31:0]       req_addr = '0;
  logic [31:0]       req_wdata = '0;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata = '0;
  logic              mem_ack = 1'b0;

  lsu_byte_sequencer #(.ADDR_W(ADDR_W), .CHECK_ALIGN(1'b1), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RESET(RESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  logic [7:0] mem [int unsigned];
  logic [7:0] ref_mem [int unsigned];
  int waits = 0;
  int ack_budget = -1;
  int wcnt = 0;
  int reqcyc = 0;
  int hold_bad = 0;
  logic              prev_req = 1'b0;
  logic              prev_cons = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0;
  logic [ADDR_W-1:0] log_addr [$];
  logic [7:0]        log_data [$];

  function automatic logic [7:0] rd_mem(input int unsigned a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  function automatic logic [31:0] ref_word(input int unsigned a);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < 4; i++)
      if (ref_mem.exists(a + i)) w[8*i +: 8] = ref_mem[a + i];
    return w;
  endfunction

  function automatic void ref_store(input int unsigned a, input logic [31:0] d, input int nbytes);
    for (int i = 0; i < nbytes; i++) ref_mem[a + i] = d[8*i +: 8];
  endfunction

  function automatic logic exp_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a > 32'h000F_FFFC);
  endfunction

  // Memory: commits on posedge, decides next ack on negedge.
  always @(posedge CLK) begin
    prev_req  = mem_req;
    prev_cons = mem_req && mem_ack;
    prev_addr = mem_addr;
    if (mem_req && mem_ack) begin
      if (mem_we) mem[32'(mem_addr)] = mem_wdata;
      log_addr.push_back(mem_addr);
      log_data.push_back(mem_wdata);
      if (ack_budget > 0) ack_budget--;
      wcnt = 0;
    end else if (mem_req) wcnt++;
    else wcnt = 0;
  end

  always @(negedge CLK) begin
    if (mem_req) begin
      reqcyc++;
      if (prev_req && !prev_cons && mem_addr != prev_addr) hold_bad++;
      mem_ack   = (ack_budget != 0) && (wcnt >= waits);
      mem_rdata = (mem_ack && !mem_we) ? rd_mem(32'(mem_addr)) : 8'($urandom);
    end else begin
      mem_ack   = 1'($urandom);
      mem_rdata = 8'($urandom);
    end
  end

  task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                        output int lat, output logic [31:0] rd_o, output logic er, output int reqc);
    int n;
    @(negedge CLK);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    n = 0;
    while (n < 50) begin
      @(posedge CLK);
      if (req_ready) break;
      n++;
    end
    if (n >= 50) begin
      tests++; fails++;
      $display("FAIL accept_timeout addr=%h got no req_ready within 50 cycles", a);
    end
    #1 req_valid = 1'b0;
    reqcyc = 0; hold_bad = 0;
    log_addr.delete(); log_data.delete();
    lat = 0; rd_o = '0; er = 1'b0;
    while (lat < 100) begin
      @(negedge CLK);
      lat++;
      if (resp_valid) begin
        rd_o = resp_rdata; er = resp_err;
        break;
      end
    end
    reqc = reqcyc;
    if (lat >= 100) begin
      tests++; fails++;
      $display("FAIL resp_timeout addr=%h got no resp_valid within 100 cycles", a);
    end
  endtask

  task automatic test_reset();
    RESET = 1'b0; req_valid = 1'b1; req_addr = 32'h10;
    repeat (3) @(negedge CLK);
    tests++;
    if ({req_ready, resp_valid, resp_rdata, resp_err, mem_req, mem_we, mem_addr, mem_wdata} !== '0) begin
      fails++;
      $display("FAIL reset_outputs got rdy=%b rv=%b rd=%h er=%b mreq=%b we=%b ma=%h wd=%h required all 0",
               req_ready, resp_valid, resp_rdata, resp_err, mem_req, mem_we, mem_addr, mem_wdata);
    end
    req_valid = 1'b0;
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    tests++;
    if (req_ready !== 1'b1) begin
      fails++; $display("FAIL reset_release_ready got %b required 1", req_ready);
    end
  endtask

  task automatic test_store_load();
    int lat, rc; logic [31:0] rd; logic er;
    waits = 0; ack_budget = -1;
    do_req(1'b1, 32'h10, 32'hDEAD_BEEF, lat, rd, er, rc);
    tests++;
    if ({lat, er, rd} !== {32'd5, 1'b0, 32'h0}) begin
      fails++; $display("FAIL store_resp got lat=%0d err=%b rd=%h required lat=5 err=0 rd=0", lat, er, rd);
    end
    tests++;
    if (log_addr.size() !== 4) begin
      fails++; $display("FAIL store_nbytes got %0d required 4", log_addr.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests++;
        if (log_addr[i] !== ADDR_W'(32'h10 + i) || log_data[i] !== 8'(32'hDEAD_BEEF >> (8*i))) begin
          fails++;
          $display("FAIL store_byte%0d got addr=%h data=%h required addr=%h data=%h", i,
                   log_addr[i], log_data[i], ADDR_W'(32'h10 + i), 8'(32'hDEAD_BEEF >> (8*i)));
        end
      end
    end
    ref_store(32'h10, 32'hDEAD_BEEF, 4);
    do_req(1'b0, 32'h10, 32'h0, lat, rd, er, rc);
    tests++;
    if ({lat, er, rd} !== {32'd5, 1'b0, ref_word(32'h10)}) begin
      fails++; $display("FAIL load_resp got lat=%0d err=%b rd=%h required lat=5 err=0 rd=%h", lat, er, rd, ref_word(32'h10));
    end
  endtask

  task automatic test_wait_states();
    int lat, rc; logic [31:0] rd; logic er;
    mem[0] = 8'h0A; mem[1] = 8'h00; mem[2] = 8'h00; mem[3] = 8'h00;
    ref_store(0, 32'h0000_000A, 4);
    waits = 2;
    do_req(1'b0, 32'h0, 32'h0, lat, rd, er, rc);
    tests++;
    if ({lat, er, rd} !== {32'd13, 1'b0, 32'h0000_000A}) begin
      fails++; $display("FAIL wait_resp got lat=%0d err=%b rd=%h required lat=13 err=0 rd=0000000a", lat, er, rd);
    end
    tests++;
    if (rc !== 12 || hold_bad !== 0) begin
      fails++; $display("FAIL wait_mem_req got req_cycles=%0d addr_moves=%0d required 12 and 0", rc, hold_bad);
    end
    waits = 0;
  endtask

  task automatic test_errors();
    int lat, rc; logic [31:0] rd; logic er;
    logic [31:0] bad [5];
    bad = '{32'h12, 32'h000F_FFFD, 32'h0010_0000, 32'hFFFF_FFFC, 32'h0000_0001};
    for (int i = 0; i < 5; i++) begin
      do_req(i == 4, bad[i], 32'h1234_5678, lat, rd, er, rc);
      tests++;
      if ({lat, er, rd, rc} !== {32'd1, 1'b1, 32'h0, 32'd0}) begin
        fails++; $display("FAIL err_addr %h got lat=%0d err=%b rd=%h req_cycles=%0d required 1 1 0 0", bad[i], lat, er, rd, rc);
      end
    end
    do_req(1'b1, 32'h000F_FFFC, 32'h8765_4321, lat, rd, er, rc);
    ref_store(32'h000F_FFFC, 32'h8765_4321, 4);
    do_req(1'b0, 32'h000F_FFFC, 32'h0, lat, rd, er, rc);
    tests++;
    if ({lat, er, rd} !== {32'd5, 1'b0, 32'h8765_4321}) begin
      fails++; $display("FAIL top_word got lat=%0d err=%b rd=%h required 5 0 87654321", lat, er, rd);
    end
  endtask

  task automatic test_timeout();
    int lat, rc; logic [31:0] rd; logic er;
    ack_budget = 0;
    do_req(1'b1, 32'h20, 32'hAABB_CCDD, lat, rd, er, rc);
    tests++;
    if ({lat, er, rd, rc} !== {32'd16, 1'b1, 32'h0, 32'd15}) begin
      fails++; $display("FAIL timeout_resp got lat=%0d err=%b rd=%h req_cycles=%0d required 16 1 0 15", lat, er, rd, rc);
    end
    @(negedge CLK);
    tests++;
    if ({req_ready, resp_valid} !== 2'b10) begin
      fails++; $display("FAIL timeout_after got ready=%b valid=%b required 1 0", req_ready, resp_valid);
    end
    ack_budget = 2;
    do_req(1'b1, 32'h30, 32'h1122_3344, lat, rd, er, rc);
    ref_store(32'h30, 32'h1122_3344, 2);
    tests++;
    if ({lat, er, rc} !== {32'd18, 1'b1, 32'd17}) begin
      fails++; $display("FAIL partial_timeout got lat=%0d err=%b req_cycles=%0d required 18 1 17", lat, er, rc);
    end
    ack_budget = -1;
    do_req(1'b0, 32'h30, 32'h0, lat, rd, er, rc);
    tests++;
    if ({er, rd} !== {1'b0, ref_word(32'h30)}) begin
      fails++; $display("FAIL partial_readback got err=%b rd=%h required 0 %h", er, rd, ref_word(32'h30));
    end
  endtask

  task automatic test_reset_mid();
    int n, seen, lat, rc; logic [31:0] rd; logic er;
    @(negedge CLK);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h40; req_wdata = 32'hCAFE_F00D;
    n = 0;
    while (n < 50) begin
      @(posedge CLK);
      if (req_ready) break;
      n++;
    end
    #1 req_valid = 1'b0;
    repeat (2) @(negedge CLK);
    tests++;
    if ({mem_req, mem_addr} !== {1'b1, ADDR_W'(32'h41)}) begin
      fails++; $display("FAIL midop_byte1 got mem_req=%b addr=%h required 1 00041", mem_req, mem_addr);
    end
    RESET = 1'b0;
    @(negedge CLK);
    tests++;
    if ({req_ready, resp_valid, resp_rdata, resp_err, mem_req, mem_we, mem_addr, mem_wdata} !== '0) begin
      fails++; $display("FAIL midop_reset_outputs got rdy=%b rv=%b mreq=%b ma=%h required all 0",
                        req_ready, resp_valid, mem_req, mem_addr);
    end
    RESET = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge CLK);
      if (resp_valid) seen++;
    end
    tests++;
    if (seen !== 0) begin
      fails++; $display("FAIL midop_no_resp got %0d resp pulses required 0", seen);
    end
    do_req(1'b0, 32'h10, 32'h0, lat, rd, er, rc);
    tests++;
    if ({lat, er, rd} !== {32'd5, 1'b0, ref_word(32'h10)}) begin
      fails++; $display("FAIL midop_fresh_load got lat=%0d err=%b rd=%h required 5 0 %h", lat, er, rd, ref_word(32'h10));
    end
  endtask

  task automatic test_back_to_back();
    int n, lat; logic [31:0] rd; logic er;
    @(negedge CLK);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h50; req_wdata = 32'h0BAD_CAFE;
    n = 0;
    while (n < 50) begin
      @(posedge CLK);
      if (req_ready) break;
      n++;
    end
    ref_store(32'h50, 32'h0BAD_CAFE, 4);
    #1 req_write = 1'b0; req_wdata = 32'hFFFF_FFFF;
    n = 0;
    while (n < 50) begin
      @(posedge CLK);
      n++;
      if (req_ready) break;
    end
    tests++;
    if (n !== 6) begin
      fails++; $display("FAIL busy_accept_gap got %0d cycles required 6", n);
    end
    #1 req_valid = 1'b0;
    lat = 0; rd = '0; er = 1'b0;
    while (lat < 100) begin
      @(negedge CLK);
      lat++;
      if (resp_valid) begin rd = resp_rdata; er = resp_err; break; end
    end
    tests++;
    if ({lat, er, rd} !== {32'd5, 1'b0, ref_word(32'h50)}) begin
      fails++; $display("FAIL busy_second got lat=%0d err=%b rd=%h required 5 0 %h", lat, er, rd, ref_word(32'h50));
    end
  endtask

  task automatic test_random();
    int lat, rc, sel, w_lat; logic [31:0] rd, a, d, e_rd; logic er, w, e_er;
    for (int t = 0; t < 30; t++) begin
      waits = $urandom_range(0, 2);
      w = 1'($urandom);
      d = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0)      a = 32'h100 + 32'($urandom_range(0, 63));
      else if (sel == 1) a = 32'h0010_0000 + ($urandom & 32'hFFF0_0000);
      else               a = 32'h100 + 32'(4 * $urandom_range(0, 15));
      e_er  = exp_err(a);
      w_lat = e_er ? 1 : 5 + 4 * waits;
      e_rd  = (!e_er && !w) ? ref_word(a) : 32'h0;
      do_req(w, a, d, lat, rd, er, rc);
      if (!e_er && w) ref_store(a, d, 4);
      tests++;
      if (lat !== w_lat || er !== e_er || rd !== e_rd || log_addr.size() !== (e_er ? 0 : 4)) begin
        fails++;
        $display("FAIL rand%0d w=%b a=%h got lat=%0d err=%b rd=%h bytes=%0d required lat=%0d err=%b rd=%h",
                 t, w, a, lat, er, rd, log_addr.size(), w_lat, e_er, e_rd);
      end
    end
    waits = 0;
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_wait_states();
    test_errors();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lsu_byte_sequencer.md
Name: lsu_byte_sequencer

Overview:
Load/store initiator that sits between the datapath's word-wide lw/sw path and the byte-wide (8-bit lane, 2^ADDR_W bytes) data memory.
It accepts one 32-bit load or store request at a time and sequences it as four single-byte memory transactions over a req/ack handshake.
Byte order is little-endian: address+0 carries bits 7:0 and address+3 carries bits 31:24.
It returns an assembled read word or an error status to the datapath.

Parameters:
ADDR_W, 20, memory byte-address width; valid addresses are 0 .. 2^ADDR_W-4.
CHECK_ALIGN, 1, when 1, a request with req_addr[1:0]!=0 is rejected with an error.
TIMEOUT, 15, maximum consecutive cycles a byte request may wait for mem_ack before the transfer aborts; range 1..255.

Ports:
CLK  in  1  clock; all state changes on posedge.
RESET  in  1  synchronous, active-low reset.
req_valid  in  1  datapath request present.
req_ready  out  1  sequencer can accept a request.
req_write  in  1  1 = store (sw), 0 = load (lw).
req_addr  in  32  byte address (ALU result).
req_wdata  in  32  store data.
resp_valid  out  1  one-cycle completion pulse.
resp_rdata  out  32  assembled load data.
resp_err  out  1  misaligned, out-of-range or timed-out request.
mem_req  out  1  byte transaction request.
mem_we  out  1  1 = byte write.
mem_addr  out  ADDR_W  byte address.
mem_wdata  out  8  write byte.
mem_rdata  in  8  read byte; valid when mem_ack=1.
mem_ack  in  1  byte transaction completes on a cycle with mem_req=1 and mem_ack=1.

Behaviour:
- Reset (RESET=0 at posedge):
  - State goes to IDLE.
  - All outputs are 0, including req_ready.
  - Byte index, timeout counter and data assembly register are cleared.
  - Reset mid-transfer aborts immediately: mem_req drops, and no resp_valid is ever issued for the aborted request.
- States: IDLE, XFER, RESP.
- IDLE:
  - req_ready=1, mem_req=0.
  - On req_valid=1, capture req_write, req_addr and req_wdata.
  - Error check at capture: err if CHECK_ALIGN=1 and addr[1:0]!=0, or if addr > 2^ADDR_W-4 (checked with full 32-bit compare).
  - If err: go to RESP with resp_err=1; no memory transaction is issued.
  - Otherwise: go to XFER with byte index k=0.
- XFER:
  - req_ready=0, mem_req=1, mem_we=captured write flag.
  - mem_addr = captured addr[ADDR_W-1:0] + k.
  - mem_wdata = wdata[8k+7:8k] for stores, 0 for loads.
  - On mem_ack: for loads, rdata[8k+7:8k] <= mem_rdata; k increments and the timeout counter clears.
  - mem_req stays high across bytes, so with a zero-wait memory the bytes complete on 4 consecutive cycles.
  - After the ack with k=3, go to RESP.
  - Each cycle with mem_req=1 and mem_ack=0 increments the timeout counter.
  - When the counter reaches TIMEOUT: go to RESP with err=1 and rdata=0. Bytes already written stay written; there is no rollback.
- RESP:
  - resp_valid=1 for exactly one cycle; then return to IDLE.
  - resp_rdata = assembled word for a successful load; 0 for stores and for errors.
  - resp_err as determined above.
  - There is no response backpressure.
- Outputs in other cycles: resp_valid=0; resp_rdata and resp_err hold 0.
- Latency (zero-wait memory): accept at cycle 0, bytes at cycles 1-4, resp_valid at cycle 5. Error requests respond at cycle 1.
- Throughput: next request is accepted in the cycle after RESP, so 6 cycles per word minimum.
- req_valid while req_ready=0 is ignored; the requester holds it.
- mem_ack while mem_req=0 is ignored.

Test Plan:
- Store, then load, zero-wait memory:
  - Store 0xDEADBEEF to addr 0x10 -> bytes EF,BE,AD,DE at 0x10..0x13 on cycles 1-4; resp_valid at cycle 5 with resp_err=0 and resp_rdata=0.
  - Load from 0x10 -> resp_rdata=0xDEADBEEF.
- Wait states: memory inserts 2 wait cycles per byte on a load of 0x0 holding 0x0000000A -> mem_addr holds during the waits; resp_valid at cycle 13 with resp_rdata=0x0000000A.
- Misaligned / out of range:
  - Load from 0x12 with CHECK_ALIGN=1 -> no mem_req; resp_valid at cycle 1 with resp_err=1 and resp_rdata=0.
  - Load from 0x000FFFFD (ADDR_W=20) -> same error response.
- Timeout: mem_ack tied 0 on a store -> mem_req high for exactly 15 cycles; then resp_err=1 pulse; req_ready returns to 1 the following cycle.
- Reset mid-op: assert RESET=0 after byte 1 of a store -> next cycle all outputs 0; no resp_valid; after release, a fresh load completes normally.
- Busy ignore: second req_valid held during XFER -> not accepted until the cycle after RESP; then accepted with correct data.
